// File: rtl/arb_types_pkg.sv
// Shared types for the I/D-cache to physical-memory arbiter.
// Holds the FSM state encoding, grant identity and default bus widths.
package arb_types_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } grant_e;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one physical memory port,
// one transaction at a time, alternating grants when both compete.
module cache_arbiter
    import arb_types_pkg::*;
#(
    parameter int unsigned s_line = LINE_W,
    parameter int unsigned s_addr = ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [s_addr-1:0] i_pmem_address,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [s_addr-1:0] mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp
);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [s_addr-1:0] addr_q;
    logic [s_line-1:0] wdata_q;
    logic              mem_read_q, mem_write_q;
    logic              i_req, d_req;
    logic              grant_i, grant_d;
    logic              busy_done;

    assign i_req     = i_pmem_read;
    assign d_req     = d_pmem_read | d_pmem_write;
    assign busy_done = (state_q != IDLE) && mem_resp;

    // Next-state and grant selection; ties go to whoever was not served last.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_d = (last_grant_q == ICACHE);
                    grant_i = (last_grant_q == DCACHE);
                end else begin
                    grant_i = i_req;
                    grant_d = d_req;
                end
                if (grant_i) begin
                    state_d      = I_BUSY;
                    last_grant_d = ICACHE;
                end else if (grant_d) begin
                    state_d      = D_BUSY;
                    last_grant_d = DCACHE;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= ICACHE;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Memory command registers: set on grant, cleared after the response cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (grant_i) begin
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
        end else if (grant_d) begin
            mem_read_q  <= ~d_pmem_write;
            mem_write_q <= d_pmem_write;
        end else if (busy_done) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end
    end

    // Request payload is captured at grant so requesters may change inputs while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_i) begin
            addr_q <= i_pmem_address;
        end else if (grant_d) begin
            addr_q <= d_pmem_address;
            if (d_pmem_write) begin
                wdata_q <= d_pmem_wdata;
            end
        end
    end

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;

    assign i_pmem_resp  = (state_q == I_BUSY) && mem_resp;
    assign d_pmem_resp  = (state_q == D_BUSY) && mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter s_line, default 256, cache line width in bits for all line data ports.
REQ-002 Parameter s_addr, default 32, address width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 i_pmem_read  input  1  I-cache line read request (I-cache never writes).
REQ-006 i_pmem_address  input  s_addr  I-cache line address.
REQ-007 i_pmem_rdata  output  s_line  line data to I-cache.
REQ-008 i_pmem_resp  output  1  I-cache transaction complete.
REQ-009 d_pmem_read  input  1  D-cache line read request.
REQ-010 d_pmem_write  input  1  D-cache line write-back request.
REQ-011 d_pmem_address  input  s_addr  D-cache line address.
REQ-012 d_pmem_wdata  input  s_line  D-cache write-back data.
REQ-013 d_pmem_rdata  output  s_line  line data to D-cache.
REQ-014 d_pmem_resp  output  1  D-cache transaction complete.
REQ-015 mem_read / mem_write  output  1 each  shared physical memory commands.
REQ-016 mem_address  output  s_addr; mem_wdata  output  s_line  shared memory address/data.
REQ-017 mem_rdata  input  s_line; mem_resp  input  1  shared memory return data / completion.

Function
REQ-018 FSM states IDLE, I_BUSY, D_BUSY; exactly one transaction outstanding on the shared port at any time.
REQ-019 IDLE: mem_read=mem_write=0, no resp asserted; samples i_pmem_read and (d_pmem_read|d_pmem_write) every cycle.
REQ-020 Only one requester active in IDLE -> next state is that requester's BUSY state.
REQ-021 Both active in IDLE -> grant the requester not recorded in last_grant; last_grant updates to the granted requester on each grant.
REQ-022 On grant, address, operation (read/write) and wdata are latched into registers; BUSY outputs are driven only from these registers, so requester input changes during BUSY have no effect.
REQ-023 d_pmem_read and d_pmem_write both asserted at grant -> latched as write.
REQ-024 Latency: request visible in IDLE at cycle t -> mem_read/mem_write asserted from cycle t+1 and held continuously until the cycle mem_resp=1.
REQ-025 BUSY with mem_resp=1: assert the granted requester's resp for exactly that cycle (combinational pass-through), deassert mem command the next cycle, return to IDLE.
REQ-026 Non-granted requester's resp stays 0 throughout; its request stays pending and is arbitrated in the next IDLE cycle.
REQ-027 i_pmem_rdata and d_pmem_rdata are both driven combinationally from mem_rdata; validity is qualified only by the respective resp.
REQ-028 mem_resp while in IDLE is ignored: no resp, no state change.
REQ-029 Minimum back-to-back spacing: one IDLE cycle between consecutive transactions on the shared port.
REQ-030 mem_wdata drives the latched D-cache wdata during D_BUSY write; otherwise it is don't-care and held at the last latched value.

Reset
REQ-031 rst=0 forces, immediately and independent of clk, state=IDLE, last_grant=ICACHE (first tie goes to D-cache), latched address/wdata=0, mem_read=mem_write=0, i_pmem_resp=d_pmem_resp=0.
REQ-032 Reset during BUSY abandons the transaction; no resp is issued for it after reset release.
REQ-033 First grant is possible in the first rising edge after rst returns high.

Structure
REQ-034 Shared package arb_types_pkg holds the state enum (IDLE/I_BUSY/D_BUSY), the grant enum (ICACHE/DCACHE) and the default line/address width constants.
REQ-035 Single module with no sub-module; next-state logic, output logic and the latching registers are kept in separate processes.

Verification
REQ-036 I-only read to 0x0000_0040, mem_resp after 3 cycles with rdata=0xA5..A5 -> mem_read high 3 cycles, i_pmem_resp one cycle, i_pmem_rdata=0xA5..A5, d_pmem_resp stays 0.
REQ-037 Simultaneous I read 0x100 and D write 0x200 after reset -> D served first (mem_write, address 0x200, wdata passed), then I read 0x100 after one IDLE cycle.
REQ-038 Repeated simultaneous requests for 4 transactions -> grants alternate D,I,D,I.
REQ-039 D read in progress while I request arrives and d_pmem_address changes to 0x300 mid-BUSY -> mem_address stays at the original value; I served after D completes.
REQ-040 rst pulled low two cycles into D_BUSY -> all outputs 0 asynchronously, no d_pmem_resp after release, next request granted normally.
REQ-041 mem_resp pulsed while IDLE with no request -> no resp outputs, state remains IDLE.
